// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller for a serial bit stream.
// A sliding-window matcher detects the sync word, and a HUNT/CONFIRM/LOCKED
// machine accepts a detection only when it lands where the frame period says
// the next sync word should end. Lock needs CONFIRM_N on-time hits in a row.
// Lock is dropped after MISS_N on-time misses in a row.
//
// Stream qualifier: din is consumed only on cycles with din_valid=1. There is
// no backpressure. A cycle with din_valid=0 changes no state and produces no
// pulses. resync is a one-cycle request that takes effect on the next edge
// whatever din_valid is.
//
// Outputs are registered. locked, frame_start and sync_err change on the edge
// that samples the qualifying bit. bit_pos is the frame counter gated by
// locked. dbg_state exposes the FSM state for observation.
module frame_sync_ctrl #(
  parameter int               PAT_W     = 4,
  parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
  parameter int               FRAME_LEN = 8,
  parameter int               CONFIRM_N = 2,
  parameter int               MISS_N    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         resync,
  output logic                         locked,
  output logic                         frame_start,
  output logic                         sync_err,
  output logic [$clog2(FRAME_LEN)-1:0] bit_pos,
  output logic [1:0]                   dbg_state
);

  localparam int CNT_W  = $clog2(FRAME_LEN);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int GOOD_W = $clog2(CONFIRM_N + 1);
  localparam int MISS_W = $clog2(MISS_N + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FRAME_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_ARMED = FILL_W'(PAT_W - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(CONFIRM_N - 1);
  localparam logic [MISS_W-1:0] MISS_LAST  = MISS_W'(MISS_N - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state;
  logic [PAT_W-2:0]    hist;     // previous PAT_W-1 valid bits, newest in LSB
  logic [FILL_W-1:0]   fill;     // valid bits seen since reset/resync, saturating
  logic [CNT_W-1:0]    cnt;      // bit position relative to last accepted hit
  logic [GOOD_W-1:0]   good;     // on-time hits collected while confirming
  logic [MISS_W-1:0]   miss;     // consecutive on-time misses while locked

  logic [PAT_W-1:0]    window;   // the PAT_W bits ending with the current din
  logic                hit;
  logic                expect_bit;
  logic [CNT_W-1:0]    cnt_next;

  // The current bit completes the window, so a match is reported in the same
  // cycle as the last sync bit arrives; only PAT_W-1 history bits are stored.
  assign window     = {hist, din};
  assign hit        = din_valid && (fill >= FILL_ARMED) && (window == PATTERN);
  assign expect_bit = din_valid && (cnt == CNT_LAST);
  assign cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

  assign bit_pos    = locked ? cnt : '0;
  assign dbg_state  = state;

  // Matcher history and fill level; resync empties the window so a stale
  // partial word cannot complete a match after the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (resync) begin
      fill <= '0;
    end else if (din_valid) begin
      hist <= window[PAT_W-2:0];
      if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Alignment FSM with its counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HUNT;
      cnt         <= '0;
      good        <= '0;
      miss        <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (resync) begin
        // Request wins over any hit or miss on this cycle; no error pulse.
        state  <= HUNT;
        locked <= 1'b0;
        cnt    <= '0;
        good   <= '0;
        miss   <= '0;
      end else if (din_valid) begin
        case (state)
          HUNT: begin
            if (hit) begin
              cnt  <= '0;
              good <= GOOD_W'(1);
              if (CONFIRM_N == 1) begin
                state       <= LOCKED;
                locked      <= 1'b1;
                miss        <= '0;
                frame_start <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            cnt <= cnt_next;
            if (expect_bit) begin
              if (hit) begin
                good <= good + 1'b1;
                if (good == GOOD_LAST) begin
                  state       <= LOCKED;
                  locked      <= 1'b1;
                  miss        <= '0;
                  frame_start <= 1'b1;
                end
              end else begin
                // Candidate did not repeat at the frame period: false sync.
                state <= HUNT;
                good  <= '0;
                cnt   <= '0;
              end
            end
          end
          LOCKED: begin
            cnt <= cnt_next;
            if (expect_bit) begin
              if (hit) begin
                miss        <= '0;
                frame_start <= 1'b1;
              end else if (miss == MISS_LAST) begin
                state    <= HUNT;
                locked   <= 1'b0;
                sync_err <= 1'b1;
                miss     <= '0;
                good     <= '0;
                cnt      <= '0;
              end else begin
                miss <= miss + 1'b1;
              end
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
